// File: rtl/l2_spi_pkg.sv
// Shared L2 SPI definitions: default word width, FSM state type and bit-position helper.
package l2_spi_pkg;

  localparam int unsigned L2_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } l2_state_e;

  // Position within the word that the cnt-th serial bit occupies.
  function automatic int unsigned l2_bit_pos(input int unsigned cnt,
                                             input int unsigned data_w,
                                             input bit          lsb_first);
    return lsb_first ? cnt : (data_w - 1 - cnt);
  endfunction

endpackage

// File: rtl/l2_recv_fifo.sv
// Small synchronous FIFO for received words; push while full is accepted only alongside a pop.
module l2_recv_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    wr_en   = push_i & (~full_o | pop_i);
    rd_en   = pop_i & ~empty_o;
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, head is masked instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l2_recv.sv
// L2 SPI receive path: samples strobed serial bits, assembles words, queues them for a consumer.
module l2_recv
  import l2_spi_pkg::*;
#(
  parameter int unsigned DATA_W     = L2_DATA_W,
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_work_en,
  input  logic              im_work_pluse,
  input  logic              im_data,
  output logic [DATA_W-1:0] om_data,
  output logic              om_valid,
  input  logic              im_ready,
  output logic              om_finish,
  output logic              om_overrun,
  output logic              om_frame_err,
  input  logic              im_err_clr
);

  localparam int unsigned CW = $clog2(DATA_W);

  l2_state_e         state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] word_d;
  logic              finish_q, frame_err_q, overrun_q;
  logic              sample, last_bit, push, pop;
  logic              fifo_full, fifo_empty;

  // Word including the bit sampled this cycle, so the final strobe can push directly.
  always_comb begin
    sample   = (state_q == SHIFT) & im_work_en & im_work_pluse;
    last_bit = (bit_cnt_q == CW'(DATA_W - 1));
    word_d   = shift_q;
    word_d[CW'(l2_bit_pos(32'(bit_cnt_q), DATA_W, LSB_FIRST != 0))] = im_data;
    push     = sample & last_bit;
    pop      = ~fifo_empty & im_ready;
  end

  // Frame FSM: bit assembly, word-complete pulse and partial-word frame error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      finish_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      finish_q    <= push;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          shift_q   <= '0;
          if (im_work_en) state_q <= SHIFT;
        end
        SHIFT: begin
          if (!im_work_en) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= (bit_cnt_q != '0);
          end else if (im_work_pluse) begin
            if (last_bit) begin
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
              shift_q   <= word_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overrun: a word arrived with no free slot; setting beats clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (push & fifo_full & ~pop) begin
      overrun_q <= 1'b1;
    end else if (im_err_clr) begin
      overrun_q <= 1'b0;
    end
  end

  l2_recv_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (word_d),
    .pop_i   (pop),
    .head_o  (om_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign om_valid     = ~fifo_empty;
  assign om_finish    = finish_q;
  assign om_overrun   = overrun_q;
  assign om_frame_err = frame_err_q;

endmodule

// File: tb/tb_l2_recv.sv
// Directed bench for l2_recv: one LSB-first and one MSB-first instance on shared stimulus.
module tb_l2_recv;

  logic       clk = 1'b0;
  logic       rst, en, pls, din, rdy, clr;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_finish, a_ovr, a_ferr;
  logic       b_valid, b_finish, b_ovr, b_ferr;
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  l2_recv #(.DATA_W(8), .LSB_FIRST(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .im_work_en(en), .im_work_pluse(pls), .im_data(din),
    .om_data(a_data), .om_valid(a_valid), .im_ready(rdy), .om_finish(a_finish),
    .om_overrun(a_ovr), .om_frame_err(a_ferr), .im_err_clr(clr)
  );

  l2_recv #(.DATA_W(8), .LSB_FIRST(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .im_work_en(en), .im_work_pluse(pls), .im_data(din),
    .om_data(b_data), .om_valid(b_valid), .im_ready(rdy), .om_finish(b_finish),
    .om_overrun(b_ovr), .om_frame_err(b_ferr), .im_err_clr(clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serialise w bit 0 first on consecutive strobes; ready/clear optionally on the last strobe.
  task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
    for (int i = 0; i < 8; i++) begin
      din = w[i];
      pls = 1'b1;
      if (i == 7) begin
        rdy = rdy_last;
        clr = clr_last;
      end
      tick();
    end
    pls = 1'b0;
    din = 1'b0;
    rdy = 1'b0;
    clr = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(a_valid), 32'd1);
    chk({tag, "_data"}, 32'(a_data), 32'(exp));
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pls = 1'b0; din = 1'b0; rdy = 1'b0; clr = 1'b0;
    tick();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data", 32'(a_data), 32'h0);
    chk("rst_finish", 32'(a_finish), 32'd0);
    chk("rst_ovr", 32'(a_ovr), 32'd0);
    chk("rst_ferr", 32'(a_ferr), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte A5
    en = 1'b1;
    tick();
    send_word(8'hA5, 1'b0, 1'b0);
    chk("a5_finish", 32'(a_finish), 32'd1);
    chk("a5_valid", 32'(a_valid), 32'd1);
    chk("a5_data", 32'(a_data), 32'hA5);
    chk("a5_b_data", 32'(b_data), 32'hA5);
    tick();
    chk("a5_finish_1cyc", 32'(a_finish), 32'd0);
    chk("a5_hold", 32'(a_data), 32'hA5);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("a5_popped", 32'(a_valid), 32'd0);

    // Back-to-back words, order and hold
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("b2b_finish", 32'(a_finish), 32'd1);
    tick();
    tick();
    chk("b2b_b_head", 32'(b_data), 32'h3C);
    pop_chk("b2b_3c", 8'h3C);
    chk("b2b_b_second", 32'(b_data), 32'hC3);
    pop_chk("b2b_c3", 8'hC3);
    chk("b2b_empty", 32'(a_valid), 32'd0);
    send_word(8'h01, 1'b0, 1'b0);
    chk("order_a", 32'(a_data), 32'h01);
    chk("order_b", 32'(b_data), 32'h80);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;

    // Overrun, clear, push+pop while full, set beats clear
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    chk("full_no_ovr", 32'(a_ovr), 32'd0);
    send_word(8'h55, 1'b0, 1'b0);
    chk("ovr_set", 32'(a_ovr), 32'd1);
    chk("ovr_head", 32'(a_data), 32'h11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clr", 32'(a_ovr), 32'd0);
    send_word(8'h66, 1'b1, 1'b0);
    chk("pushpop_ovr", 32'(a_ovr), 32'd0);
    chk("pushpop_head", 32'(a_data), 32'h22);
    send_word(8'h77, 1'b0, 1'b1);
    chk("set_wins", 32'(a_ovr), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pop_chk("drain_22", 8'h22);
    pop_chk("drain_33", 8'h33);
    pop_chk("drain_44", 8'h44);
    pop_chk("drain_66", 8'h66);
    chk("drain_empty", 32'(a_valid), 32'd0);

    // Frame error on partial word, then a clean word
    for (int i = 0; i < 3; i++) begin
      din = 1'b1; pls = 1'b1;
      tick();
    end
    pls = 1'b0; din = 1'b0; en = 1'b0;
    tick();
    chk("ferr_pulse", 32'(a_ferr), 32'd1);
    chk("ferr_no_push", 32'(a_valid), 32'd0);
    tick();
    chk("ferr_1cyc", 32'(a_ferr), 32'd0);
    en = 1'b1;
    tick();
    send_word(8'h0F, 1'b0, 1'b0);
    chk("ferr_next_word", 32'(a_data), 32'h0F);
    pop_chk("ferr_pop", 8'h0F);
    en = 1'b0;
    tick();
    chk("fall_cnt0_noerr", 32'(a_ferr), 32'd0);

    // Ignored strobes: in the en-falling cycle and while en is low
    en = 1'b1;
    tick();
    en = 1'b0; pls = 1'b1; din = 1'b1;
    tick();
    chk("fall_strobe_noerr", 32'(a_ferr), 32'd0);
    tick();
    tick();
    pls = 1'b0; din = 1'b0; en = 1'b1;
    tick();
    send_word(8'h5A, 1'b0, 1'b0);
    chk("ign_finish", 32'(a_finish), 32'd1);
    chk("ign_data", 32'(a_data), 32'h5A);
    pop_chk("ign_pop", 8'h5A);

    // Asynchronous reset mid-frame with a queued word and partial bits
    send_word(8'hAA, 1'b0, 1'b0);
    chk("pre_rst_finish", 32'(a_finish), 32'd1);
    for (int i = 0; i < 3; i++) begin
      din = 1'b1; pls = 1'b1;
      tick();
    end
    pls = 1'b0; din = 1'b0;
    rst = 1'b1;
    #2;
    chk("arst_valid", 32'(a_valid), 32'd0);
    chk("arst_data", 32'(a_data), 32'h0);
    chk("arst_b_valid", 32'(b_valid), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(a_valid), 32'd0);
    send_word(8'h81, 1'b0, 1'b0);
    chk("post_rst_word", 32'(a_data), 32'h81);
    chk("post_rst_b_word", 32'(b_data), 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
